// File: rtl/mips_pipeline_top.sv
// mips_pipeline_top: 5-stage MIPS subset core with internal instruction ROM, register file and data RAM
module mips_pipeline_top #(
  parameter int IMEM_WORDS = 32,
  parameter int DMEM_WORDS = 32
) (
  input logic clk,
  input logic reset
);
  localparam int ia = $clog2(IMEM_WORDS);
  localparam int da = $clog2(DMEM_WORDS);
  localparam logic [31:0] pc_mask = 32'(IMEM_WORDS * 4 - 1);
  function automatic logic [31:0] rom(input logic [ia-1:0] a);
    case (a)
      5'd0: rom = 32'h20010005;
      5'd1: rom = 32'h20020003;
      5'd2: rom = 32'h00221820;
      5'd3: rom = 32'hac030000;
      5'd4: rom = 32'h8c040000;
      5'd5: rom = 32'h00812822;
      5'd6: rom = 32'h0041302a;
      5'd7: rom = 32'h10000001;
      5'd8: rom = 32'h20070063;
      5'd9: rom = 32'h08000009;
      default: rom = 32'h0;
    endcase
  endfunction
  logic [31:0] pc, pc4, pc_next, if_instr;
  logic [31:0] ifid_instr, ifid_pc4;
  logic [31:0] rf [32];
  logic [31:0] dmem [DMEM_WORDS];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, id_dst;
  logic [31:0] imm, rd_a, rd_b, j_target;
  logic r_ok, is_addi, is_lw, is_sw, is_beq, is_j, id_we, load_use, stall, bubble;
  logic [2:0] id_aluop;
  logic idex_we, idex_mr, idex_mw, idex_br, idex_alusrc;
  logic [2:0] idex_aluop;
  logic [4:0] idex_rs, idex_rt, idex_dst;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc4;
  logic [31:0] fa, fb, alu_b, alu_y, br_target;
  logic take;
  logic exmem_we, exmem_mr, exmem_mw;
  logic [4:0] exmem_dst;
  logic [31:0] exmem_alu, exmem_b, mem_rdata;
  logic memwb_we;
  logic [4:0] memwb_dst;
  logic [31:0] memwb_data;
  assign pc4 = pc + 32'd4;
  assign if_instr = rom(pc[ia+1:2]);
  assign op = ifid_instr[31:26];
  assign rs = ifid_instr[25:21];
  assign rt = ifid_instr[20:16];
  assign rd = ifid_instr[15:11];
  assign funct = ifid_instr[5:0];
  assign imm = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
  assign r_ok = op == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                funct == 6'h25 || funct == 6'h2a);
  assign is_addi = op == 6'h08;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2b;
  assign is_beq = op == 6'h04;
  assign is_j = op == 6'h02;
  assign id_we = r_ok || is_addi || is_lw;
  assign id_dst = !id_we ? 5'd0 : r_ok ? rd : rt;
  assign id_aluop = !r_ok ? 3'd0 : funct == 6'h22 ? 3'd1 : funct == 6'h24 ? 3'd2 :
                    funct == 6'h25 ? 3'd3 : funct == 6'h2a ? 3'd4 : 3'd0;
  // the register being written back this cycle is seen by the ID read
  assign rd_a = rs == 5'd0 ? 32'd0 : (memwb_we && memwb_dst == rs) ? memwb_data : rf[rs];
  assign rd_b = rt == 5'd0 ? 32'd0 : (memwb_we && memwb_dst == rt) ? memwb_data : rf[rt];
  assign j_target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
  assign load_use = idex_mr && idex_dst != 5'd0 && (idex_dst == rs || idex_dst == rt);
  assign fa = (exmem_we && exmem_dst != 5'd0 && exmem_dst == idex_rs) ? exmem_alu :
              (memwb_we && memwb_dst != 5'd0 && memwb_dst == idex_rs) ? memwb_data : idex_a;
  assign fb = (exmem_we && exmem_dst != 5'd0 && exmem_dst == idex_rt) ? exmem_alu :
              (memwb_we && memwb_dst != 5'd0 && memwb_dst == idex_rt) ? memwb_data : idex_b;
  assign alu_b = idex_alusrc ? idex_imm : fb;
  assign alu_y = idex_aluop == 3'd1 ? fa - alu_b :
                 idex_aluop == 3'd2 ? fa & alu_b :
                 idex_aluop == 3'd3 ? fa | alu_b :
                 idex_aluop == 3'd4 ? {31'd0, $signed(fa) < $signed(alu_b)} : fa + alu_b;
  assign br_target = idex_pc4 + (idex_imm << 2);
  assign take = idex_br && fa == fb;
  // a taken branch squashes whatever the stall was protecting
  assign stall = load_use && !take;
  assign bubble = take || stall;
  assign pc_next = take ? br_target : stall ? pc : is_j ? j_target : pc4;
  assign mem_rdata = dmem[exmem_alu[da+1:2]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      ifid_instr <= '0;
      ifid_pc4 <= '0;
      idex_we <= 1'b0;
      idex_mr <= 1'b0;
      idex_mw <= 1'b0;
      idex_br <= 1'b0;
      idex_alusrc <= 1'b0;
      idex_aluop <= '0;
      idex_rs <= '0;
      idex_rt <= '0;
      idex_dst <= '0;
      idex_a <= '0;
      idex_b <= '0;
      idex_imm <= '0;
      idex_pc4 <= '0;
      exmem_we <= 1'b0;
      exmem_mr <= 1'b0;
      exmem_mw <= 1'b0;
      exmem_dst <= '0;
      exmem_alu <= '0;
      exmem_b <= '0;
      memwb_we <= 1'b0;
      memwb_dst <= '0;
      memwb_data <= '0;
    end else begin
      pc <= pc_next & pc_mask;
      if (take || (is_j && !stall)) begin
        ifid_instr <= '0;
        ifid_pc4 <= '0;
      end else if (!stall) begin
        ifid_instr <= if_instr;
        ifid_pc4 <= pc4;
      end
      if (bubble) begin
        idex_we <= 1'b0;
        idex_mr <= 1'b0;
        idex_mw <= 1'b0;
        idex_br <= 1'b0;
        idex_alusrc <= 1'b0;
        idex_aluop <= '0;
        idex_rs <= '0;
        idex_rt <= '0;
        idex_dst <= '0;
        idex_a <= '0;
        idex_b <= '0;
        idex_imm <= '0;
        idex_pc4 <= '0;
      end else begin
        idex_we <= id_we;
        idex_mr <= is_lw;
        idex_mw <= is_sw;
        idex_br <= is_beq;
        idex_alusrc <= is_addi || is_lw || is_sw;
        idex_aluop <= id_aluop;
        idex_rs <= rs;
        idex_rt <= rt;
        idex_dst <= id_dst;
        idex_a <= rd_a;
        idex_b <= rd_b;
        idex_imm <= imm;
        idex_pc4 <= ifid_pc4;
      end
      exmem_we <= idex_we;
      exmem_mr <= idex_mr;
      exmem_mw <= idex_mw;
      exmem_dst <= idex_dst;
      exmem_alu <= alu_y;
      exmem_b <= fb;
      memwb_we <= exmem_we;
      memwb_dst <= exmem_dst;
      memwb_data <= exmem_mr ? mem_rdata : exmem_alu;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (memwb_we && memwb_dst != 5'd0)
      rf[memwb_dst] <= memwb_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    else if (exmem_mw)
      dmem[exmem_alu[da+1:2]] <= exmem_b;
  end
endmodule

// File: tb/tb_mips_pipeline_top.sv
// tb_mips_pipeline_top: scoreboard of register/memory writebacks (edge, location, value) plus pipeline state checks
module tb_mips_pipeline_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #15 clk = ~clk;
  mips_pipeline_top dut (.clk(clk), .reset(reset));
  typedef struct packed {
    logic [7:0] en;
    logic [7:0] idx;
    logic [31:0] val;
  } wb_t;
  wb_t exp_q[$];
  int n_tests, n_fail, en;
  logic [31:0] rf_snap [32];
  logic [31:0] dm_snap [32];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push_wb(input int e, input int idx, input logic [31:0] val);
    wb_t w;
    w.en = 8'(e);
    w.idx = 8'(idx);
    w.val = val;
    exp_q.push_back(w);
  endtask
  // idx 0..31 are registers, 32+n is data word n
  task automatic start_run();
    en = 0;
    for (int i = 0; i < 32; i++) begin
      rf_snap[i] = '0;
      dm_snap[i] = '0;
    end
    exp_q.delete();
    push_wb(5, 1, 32'd5);
    push_wb(6, 2, 32'd3);
    push_wb(7, 3, 32'd8);
    push_wb(7, 32, 32'd8);
    push_wb(9, 4, 32'd8);
    push_wb(11, 5, 32'd3);
    push_wb(12, 6, 32'd1);
  endtask
  task automatic observe(input int idx, input logic [31:0] val);
    wb_t got;
    got.en = 8'(en);
    got.idx = 8'(idx);
    got.val = val;
    if (exp_q.size() == 0) chk("sb_extra", 64'(got), 64'd0);
    else chk("sb_wb", 64'(got), 64'(exp_q.pop_front()));
  endtask
  task automatic step();
    @(posedge clk);
    en++;
    @(negedge clk);
    for (int i = 0; i < 32; i++)
      if (dut.rf[i] !== rf_snap[i]) begin
        observe(i, dut.rf[i]);
        rf_snap[i] = dut.rf[i];
      end
    for (int i = 0; i < 32; i++)
      if (dut.dmem[i] !== dm_snap[i]) begin
        observe(32 + i, dut.dmem[i]);
        dm_snap[i] = dut.dmem[i];
      end
  endtask
  task automatic chk_reset(input string p);
    logic [31:0] acc_rf, acc_dm;
    acc_rf = '0;
    acc_dm = '0;
    for (int i = 0; i < 32; i++) begin
      acc_rf |= dut.rf[i];
      acc_dm |= dut.dmem[i];
    end
    chk({p, "_pc"}, dut.pc, 0);
    chk({p, "_rf"}, acc_rf, 0);
    chk({p, "_dm"}, acc_dm, 0);
    chk({p, "_data"}, dut.ifid_instr | dut.ifid_pc4 | dut.idex_a | dut.idex_b | dut.idex_imm |
        dut.idex_pc4 | dut.exmem_alu | dut.exmem_b | dut.memwb_data, 0);
    chk({p, "_ctl"}, {dut.idex_we, dut.idex_mr, dut.idex_mw, dut.idex_br, dut.idex_alusrc,
        dut.idex_aluop, dut.idex_dst, dut.exmem_we, dut.exmem_mr, dut.exmem_mw, dut.exmem_dst,
        dut.memwb_we, dut.memwb_dst}, 0);
  endtask
  task automatic final_checks(input string p);
    chk({p, "_r1"}, dut.rf[1], 5);
    chk({p, "_r2"}, dut.rf[2], 3);
    chk({p, "_r3"}, dut.rf[3], 8);
    chk({p, "_r4"}, dut.rf[4], 8);
    chk({p, "_r5"}, dut.rf[5], 3);
    chk({p, "_r6"}, dut.rf[6], 1);
    chk({p, "_r7"}, dut.rf[7], 0);
    chk({p, "_m0"}, dut.dmem[0], 8);
    chk({p, "_sb_left"}, exp_q.size(), 0);
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    #1 reset = 1'b1;
    #4 chk_reset("rst_init");
    #5 reset = 1'b0;
    start_run();
    repeat (4) step();
    chk("r1_pre", dut.rf[1], 0);
    step();
    chk("r1_e5", dut.rf[1], 5);
    step();
    chk("r2_e6", dut.rf[2], 3);
    chk("pc_e6", dut.pc, 32'h18);
    chk("lw_in_ex", dut.idex_mr, 1);
    step();
    chk("pc_hold", dut.pc, 32'h18);
    chk("ifid_hold", dut.ifid_instr, 32'h00812822);
    chk("idex_bubble", {dut.idex_we, dut.idex_mr, dut.idex_mw, dut.idex_br, dut.idex_dst}, 0);
    step();
    chk("pc_e8", dut.pc, 32'h1c);
    repeat (3) step();
    chk("flush_ifid", dut.ifid_instr, 0);
    chk("flush_idex", {dut.idex_we, dut.idex_mr, dut.idex_mw, dut.idex_br, dut.idex_dst,
        dut.idex_imm, dut.idex_a}, 0);
    chk("pc_br", dut.pc, 32'h24);
    repeat (16) step();
    chk("pc_park", dut.pc, 32'h24);
    step();
    chk("j_loop", dut.ifid_instr, 32'h08000009);
    final_checks("run1");
    force dut.ifid_instr = 32'h20000007;
    step();
    release dut.ifid_instr;
    repeat (5) step();
    chk("r0_zero", dut.rf[0], 0);
    start_run();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    start_run();
    repeat (8) step();
    chk("mid_m0", dut.dmem[0], 8);
    #2 reset = 1'b1;
    #1 chk_reset("rst_mid");
    #5 reset = 1'b0;
    start_run();
    repeat (27) step();
    chk("pc_park2", dut.pc, 32'h24);
    step();
    final_checks("run2");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
